// File: rtl/imem_fetch_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency instruction BRAM read port among NUM_REQ fetch units.
// Each requester gets a held, backpressurable response slot. Defining IMEM_ARB_STATS_EN adds grant/conflict counters.
module imem_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0] rsp_data,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  input  logic [NUM_REQ-1:0]        flush,
  output logic                      mem_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]               stat_grants,
  output logic [31:0]               stat_conflicts
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } slot_state_t;

  slot_state_t               r_state [NUM_REQ];
  logic [NUM_REQ-1:0]        r_drop;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] r_rsp_data;
  logic [PTR_W-1:0]          r_ptr;
  logic                      r_mem_en;
  logic [ADDR_W-1:0]         r_mem_addr;

  logic [NUM_REQ-1:0]        w_elig;
  logic [NUM_REQ-1:0]        w_gnt;
  logic                      w_any_gnt;
  logic [PTR_W-1:0]          w_gnt_idx;
  logic [ADDR_W-1:0]         w_gnt_addr;

  // A held slot may be re-granted in the very cycle its response is consumed.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = rst_n & req_valid[i] & ~flush[i] &
                  ((r_state[i] == S_IDLE) | ((r_state[i] == S_HOLD) & rsp_ready[i]));
    end
  end

  // Scan eligible requesters starting at the pointer, wrapping, and take the first hit.
  always_comb begin
    int  sum;
    int  idx;
    logic hit;
    w_any_gnt  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_addr = '0;
    sum        = 0;
    idx        = 0;
    hit        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum       = int'(r_ptr) + k;
      idx       = (sum >= NUM_REQ) ? (sum - NUM_REQ) : sum;
      hit       = ~w_any_gnt & w_elig[idx[PTR_W-1:0]];
      w_gnt_idx = hit ? idx[PTR_W-1:0] : w_gnt_idx;
      w_any_gnt = w_any_gnt | hit;
    end
    w_gnt = {{(NUM_REQ-1){1'b0}}, w_any_gnt} << w_gnt_idx;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_addr = w_gnt_addr | ({ADDR_W{w_gnt[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
    end
  end

  // Per-requester slot FSM; a flush during ISSUE/WAIT lets the read finish but drops its data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_state[i] <= S_IDLE;
      end
      r_drop      <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        case (r_state[i])
          S_IDLE: begin
            if (w_gnt[i]) begin
              r_state[i] <= S_ISSUE;
            end else begin
              r_state[i] <= S_IDLE;
            end
          end
          S_ISSUE: begin
            r_state[i] <= S_WAIT;
            r_drop[i]  <= flush[i];
          end
          S_WAIT: begin
            r_drop[i] <= 1'b0;
            if (flush[i] | r_drop[i]) begin
              r_state[i] <= S_IDLE;
            end else begin
              r_state[i]                      <= S_HOLD;
              r_rsp_valid[i]                  <= 1'b1;
              r_rsp_data[i*DATA_W +: DATA_W]  <= mem_rdata;
            end
          end
          S_HOLD: begin
            if (w_gnt[i]) begin
              r_state[i]     <= S_ISSUE;
              r_rsp_valid[i] <= 1'b0;
            end else if (flush[i] | rsp_ready[i]) begin
              r_state[i]     <= S_IDLE;
              r_rsp_valid[i] <= 1'b0;
            end else begin
              r_state[i]     <= S_HOLD;
            end
          end
          default: begin
            r_state[i]     <= S_IDLE;
            r_drop[i]      <= 1'b0;
            r_rsp_valid[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // Pointer advance and registered BRAM command; address holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      r_mem_en <= w_any_gnt;
      if (w_any_gnt) begin
        r_mem_addr <= w_gnt_addr;
        r_ptr      <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + PTR_W'(1));
      end else begin
        r_mem_addr <= r_mem_addr;
        r_ptr      <= r_ptr;
      end
    end
  end

`ifdef IMEM_ARB_STATS_EN
  logic        w_multi;
  logic [31:0] r_stat_grants;
  logic [31:0] r_stat_conflicts;

  assign w_multi = |(w_elig & (w_elig - NUM_REQ'(1)));

  // Free-running wrap-around counters of grants and contended cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_grants    <= 32'd0;
      r_stat_conflicts <= 32'd0;
    end else begin
      r_stat_grants    <= r_stat_grants + {31'd0, w_any_gnt};
      r_stat_conflicts <= r_stat_conflicts + {31'd0, w_multi};
    end
  end

  assign stat_grants    = r_stat_grants;
  assign stat_conflicts = r_stat_conflicts;
`endif

  assign req_ready = w_gnt;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign mem_en    = r_mem_en;
  assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed self-checking bench for imem_fetch_arbiter with a 1-cycle-latency BRAM model.
module tb_imem_fetch_arbiter;
  localparam int NR = 4;

  logic          clk;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  logic [NR*32-1:0] req_addr;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] rsp_valid;
  logic [NR*32-1:0] rsp_data;
  logic [NR-1:0] rsp_ready;
  logic [NR-1:0] flush;
  logic          mem_en;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0]   stat_grants;
  logic [31:0]   stat_conflicts;
`endif

  int total = 0;
  int bad   = 0;

  imem_fetch_arbiter #(.NUM_REQ(NR), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .flush(flush), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bram_f(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : ((a ^ 32'hC0DE_0000) + 32'h0000_0011);
  endfunction

  // BRAM: data for the address presented with mem_en appears on the next cycle.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= bram_f(mem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'h0;
    flush     = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic set_addr(input int i, input logic [31:0] a);
    req_addr[i*32 +: 32] = a;
  endtask

  function automatic logic [31:0] rd(input int i);
    return rsp_data[i*32 +: 32];
  endfunction

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_addr  = '0;
    rsp_ready = 4'hF;
    flush     = 4'h0;
    tick();
    tick();

    // Reset state, with requests present to show grants are blocked.
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_mem_en", 64'(mem_en), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr), 64'h0);
    chk("rst_rsp_data_lo", rsp_data[63:0], 64'h0);
    chk("rst_rsp_data_hi", rsp_data[127:64], 64'h0);
`ifdef IMEM_ARB_STATS_EN
    chk("rst_stat_grants", 64'(stat_grants), 64'h0);
    chk("rst_stat_conflicts", 64'(stat_conflicts), 64'h0);
`endif

    // Single fetch: grant T, mem_en T+1, rsp_valid T+3 for one cycle.
    do_reset();
    set_addr(0, 32'h0000_0100);
    rsp_ready = 4'hF;
    req_valid = 4'b0001;
    #1;
    chk("t1_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'h0;
    #1;
    chk("t1_mem_en", 64'(mem_en), 64'h1);
    chk("t1_mem_addr", 64'(mem_addr), 64'h100);
    chk("t1_no_rsp_t1", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_mem_en_off", 64'(mem_en), 64'h0);
    chk("t1_mem_addr_hold", 64'(mem_addr), 64'h100);
    chk("t1_no_rsp_t2", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_data", 64'(rd(0)), 64'hDEAD_BEEF);
    tick();
    chk("t1_rsp_drop", 64'(rsp_valid), 64'h0);

    // All requesters continuously: strict rotation 0,1,2,3,...
    do_reset();
    for (int i = 0; i < NR; i++) set_addr(i, 32'h0000_1000 + 32'(i * 4));
    rsp_ready = 4'hF;
    req_valid = 4'hF;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("t2_rr_grant", 64'(req_ready), 64'(4'b0001 << (c % 4)));
      if (c >= 1) begin
        chk("t2_mem_addr", 64'(mem_addr), 64'(32'h0000_1000 + 32'(((c - 1) % 4) * 4)));
      end
      if (c == 3) begin
        chk("t2_rsp0_valid", 64'(rsp_valid[0]), 64'h1);
        chk("t2_rsp0_data", 64'(rd(0)), 64'(bram_f(32'h0000_1000)));
      end
      tick();
    end
`ifdef IMEM_ARB_STATS_EN
    chk("t2_stat_grants", 64'(stat_grants), 64'd8);
    chk("t2_stat_conflicts", 64'(stat_conflicts), 64'd8);
`endif
    req_valid = 4'h0;
    repeat (4) tick();

    // Requester 1 stalls its response; requester 0 keeps being served every 3 cycles.
    do_reset();
    set_addr(0, 32'h0000_2000);
    set_addr(1, 32'h0000_0200);
    rsp_ready = 4'b1101;
    req_valid = 4'b0011;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (c == 1)      chk("t3_grant", 64'(req_ready), 64'h2);
      else if (c == 2) chk("t3_grant", 64'(req_ready), 64'h0);
      else             chk("t3_grant", 64'(req_ready), 64'((c % 3 == 0) ? 4'b0001 : 4'b0000));
      if (c >= 4) begin
        chk("t3_hold_valid", 64'(rsp_valid[1]), 64'h1);
        chk("t3_hold_data", 64'(rd(1)), 64'(bram_f(32'h0000_0200)));
      end
      tick();
    end
    rsp_ready = 4'hF;
    #1;
    chk("t3_consume_regrant", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'h0;
    #1;
    chk("t3_after_consume", 64'(rsp_valid), 64'h1);
    repeat (4) tick();

    // Flush in WAIT discards the fetch; flush blocks a same-cycle grant and drops HOLD.
    do_reset();
    set_addr(2, 32'h0000_0300);
    rsp_ready = 4'hF;
    req_valid = 4'b0100;
    #1;
    chk("t4_grant", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'h0;
    tick();
    flush = 4'b0100;
    #1;
    chk("t4_wait_no_rsp", 64'(rsp_valid), 64'h0);
    tick();
    flush     = 4'h0;
    req_valid = 4'b0100;
    set_addr(2, 32'h0000_0304);
    #1;
    chk("t4_flushed_no_rsp", 64'(rsp_valid), 64'h0);
    chk("t4_regrant", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'h0;
    #1;
    chk("t4_issue_no_rsp", 64'(rsp_valid), 64'h0);
    tick();
    tick();
    rsp_ready = 4'b1011;
    flush     = 4'b0100;
    req_valid = 4'b0100;
    #1;
    chk("t4_new_rsp", 64'(rsp_valid), 64'h4);
    chk("t4_new_data", 64'(rd(2)), 64'(bram_f(32'h0000_0304)));
    chk("t4_flush_blocks_grant", 64'(req_ready), 64'h0);
    tick();
    flush     = 4'h0;
    req_valid = 4'h0;
    #1;
    chk("t4_hold_flushed", 64'(rsp_valid), 64'h0);
    chk("t4_no_mem_en", 64'(mem_en), 64'h0);
    rsp_ready = 4'hF;

    // Requester 3 consumes and is re-granted in the same cycle.
    do_reset();
    set_addr(3, 32'h0000_0400);
    req_valid = 4'b1000;
    #1;
    chk("t5_grant", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'h0;
    tick();
    tick();
    req_valid = 4'b1000;
    set_addr(3, 32'h0000_0404);
    #1;
    chk("t5_rsp_valid", 64'(rsp_valid), 64'h8);
    chk("t5_rsp_data", 64'(rd(3)), 64'(bram_f(32'h0000_0400)));
    chk("t5_regrant", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'h0;
    #1;
    chk("t5_rsp_drop", 64'(rsp_valid), 64'h0);
    chk("t5_mem_en", 64'(mem_en), 64'h1);
    chk("t5_mem_addr", 64'(mem_addr), 64'h404);
    tick();
    chk("t5_rsp_low2", 64'(rsp_valid), 64'h0);
    tick();
    chk("t5_rsp_new", 64'(rsp_valid), 64'h8);
    chk("t5_data_new", 64'(rd(3)), 64'(bram_f(32'h0000_0404)));

    // Reset while two fetches are in flight.
    do_reset();
    set_addr(0, 32'h0000_0500);
    set_addr(1, 32'h0000_0600);
    req_valid = 4'b0011;
    #1;
    chk("t6_grant0", 64'(req_ready), 64'h1);
    tick();
    chk("t6_grant1", 64'(req_ready), 64'h2);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 64'(req_ready), 64'h0);
    tick();
    chk("t6_rst_rsp", 64'(rsp_valid), 64'h0);
    chk("t6_rst_mem_en", 64'(mem_en), 64'h0);
    chk("t6_rst_mem_addr", 64'(mem_addr), 64'h0);
    rst_n     = 1'b1;
    req_valid = 4'h0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("t6_no_stale", 64'(rsp_valid), 64'h0);
    end
    req_valid = 4'hF;
    #1;
    chk("t6_ptr_zero", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'h0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
